// File: rtl/mutex_requester.sv
// Client-side front end for a round-robin mutex arbiter: requests the lock, issues
// buffered commands on the shared bus, then releases. Optional macro: MUTEX_REQUESTER_TIMEOUT_EN.
module mutex_requester #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int MAX_HOLD  = 16,
  parameter int GAP_LIMIT = 4,
  parameter int TIMEOUT   = 1024
) (
  input  logic              ipClk,
  input  logic              ipReset,
  input  logic              ipCmdValid,
  output logic              opCmdReady,
  input  logic              ipCmdWrite,
  input  logic              ipCmdLast,
  input  logic [ADDR_W-1:0] ipCmdAddress,
  input  logic [DATA_W-1:0] ipCmdData,
  output logic              opRspValid,
  output logic [DATA_W-1:0] opRspData,
  output logic              opRequest,
  input  logic              ipGrant,
  output logic              opBusValid,
  input  logic              ipBusReady,
  output logic              opBusWrite,
  output logic [ADDR_W-1:0] opBusAddress,
  output logic [DATA_W-1:0] opBusWriteData,
  input  logic [DATA_W-1:0] ipBusReadData,
  output logic              opTimeout,
  output logic              opAbort
);
  localparam int CNT_W = $clog2(MAX_HOLD + 1);
  localparam int GAP_W = $clog2(GAP_LIMIT + 1);

  if (MAX_HOLD < 1 || GAP_LIMIT < 1 || TIMEOUT < 1) begin : g_param_check
    $error("mutex_requester: MAX_HOLD, GAP_LIMIT and TIMEOUT must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, REQUEST, ACTIVE, RELEASE} state_t;

  state_t              state_q, state_d;
  logic                rst_q;
  logic                hold_full_q, hold_full_d;
  logic                hold_write_q, hold_write_d;
  logic                hold_last_q, hold_last_d;
  logic [ADDR_W-1:0]   hold_addr_q, hold_addr_d;
  logic [DATA_W-1:0]   hold_data_q, hold_data_d;
  logic [CNT_W-1:0]    xfer_cnt_q, xfer_cnt_d;
  logic [GAP_W-1:0]    gap_q, gap_d, gap_inc;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                abort_q, abort_d;
  logic                bus_valid, bus_xfer, cmd_ready, cmd_accept;
`ifdef MUTEX_REQUESTER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic                timeout_q, timeout_d;
`endif

  // Grant loss gates the bus immediately, so a transfer never completes without the lock.
  assign bus_valid  = hold_full_q & (state_q == ACTIVE) & ipGrant;
  assign bus_xfer   = bus_valid & ipBusReady;
  assign cmd_ready  = (state_q == ACTIVE) & (~hold_full_q | bus_xfer);
  assign cmd_accept = ipCmdValid & cmd_ready;
  assign gap_inc    = (gap_q == GAP_W'(GAP_LIMIT)) ? gap_q : gap_q + GAP_W'(1);

  always_comb begin
    state_d      = state_q;
    hold_full_d  = hold_full_q;
    hold_write_d = hold_write_q;
    hold_last_d  = hold_last_q;
    hold_addr_d  = hold_addr_q;
    hold_data_d  = hold_data_q;
    xfer_cnt_d   = xfer_cnt_q;
    gap_d        = gap_q;
    rsp_valid_d  = 1'b0;
    rsp_data_d   = rsp_data_q;
    abort_d      = 1'b0;
`ifdef MUTEX_REQUESTER_TIMEOUT_EN
    to_cnt_d     = '0;
    timeout_d    = 1'b0;
`endif
    if (bus_xfer) begin
      hold_full_d = 1'b0;
      xfer_cnt_d  = xfer_cnt_q + CNT_W'(1);
      if (!hold_write_q) begin
        rsp_valid_d = 1'b1;
        rsp_data_d  = ipBusReadData;
      end
    end
    if (cmd_accept) begin
      hold_full_d  = 1'b1;
      hold_write_d = ipCmdWrite;
      hold_last_d  = ipCmdLast;
      hold_addr_d  = ipCmdAddress;
      hold_data_d  = ipCmdData;
    end
    unique case (state_q)
      // A command left over from an aborted grant also needs the lock again.
      IDLE: if (ipCmdValid || hold_full_q) state_d = REQUEST;
      REQUEST: begin
        if (ipGrant) begin
          state_d    = ACTIVE;
          xfer_cnt_d = '0;
          gap_d      = '0;
        end
`ifdef MUTEX_REQUESTER_TIMEOUT_EN
        else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
          state_d   = RELEASE;
          timeout_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
`endif
      end
      ACTIVE: begin
        if (!ipGrant) begin
          state_d = RELEASE;
          abort_d = 1'b1;
        end else if (bus_xfer && (hold_last_q || (xfer_cnt_q + CNT_W'(1)) == CNT_W'(MAX_HOLD))) begin
          state_d = RELEASE;
        end else if (!hold_full_q && !ipCmdValid) begin
          gap_d = gap_inc;
          if (gap_inc == GAP_W'(GAP_LIMIT)) state_d = RELEASE;
        end else begin
          gap_d = '0;
        end
      end
      RELEASE: if (!ipGrant) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ipClk) begin
    rst_q <= ipReset;
    if (rst_q) begin
      state_q      <= IDLE;
      hold_full_q  <= 1'b0;
      hold_write_q <= 1'b0;
      hold_last_q  <= 1'b0;
      hold_addr_q  <= '0;
      hold_data_q  <= '0;
      xfer_cnt_q   <= '0;
      gap_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      abort_q      <= 1'b0;
`ifdef MUTEX_REQUESTER_TIMEOUT_EN
      to_cnt_q     <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      hold_full_q  <= hold_full_d;
      hold_write_q <= hold_write_d;
      hold_last_q  <= hold_last_d;
      hold_addr_q  <= hold_addr_d;
      hold_data_q  <= hold_data_d;
      xfer_cnt_q   <= xfer_cnt_d;
      gap_q        <= gap_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      abort_q      <= abort_d;
`ifdef MUTEX_REQUESTER_TIMEOUT_EN
      to_cnt_q     <= to_cnt_d;
      timeout_q    <= timeout_d;
`endif
    end
  end

  assign opRequest      = (state_q == REQUEST) | (state_q == ACTIVE);
  assign opCmdReady     = cmd_ready;
  assign opBusValid     = bus_valid;
  assign opBusWrite     = hold_write_q;
  assign opBusAddress   = hold_addr_q;
  assign opBusWriteData = hold_data_q;
  assign opRspValid     = rsp_valid_q;
  assign opRspData      = rsp_data_q;
  assign opAbort        = abort_q;
`ifdef MUTEX_REQUESTER_TIMEOUT_EN
  assign opTimeout      = timeout_q;
`else
  assign opTimeout      = 1'b0;
`endif
endmodule

// File: tb/tb_mutex_requester.sv
// Scoreboard bench for mutex_requester: stimulus queues expected bus transfers and
// read responses; a negedge monitor pops and compares whenever the DUT presents them.
`timescale 1ns/1ps
module tb_mutex_requester;
  localparam int ADDR_W = 16, DATA_W = 32, MAX_HOLD = 16, GAP_LIMIT = 4, TIMEOUT = 8;
  localparam int GRANT_DLY = 2;

  logic              clk;
  logic              ipReset, ipCmdValid, opCmdReady, ipCmdWrite, ipCmdLast;
  logic [ADDR_W-1:0] ipCmdAddress, opBusAddress;
  logic [DATA_W-1:0] ipCmdData, opRspData, opBusWriteData, ipBusReadData;
  logic              opRspValid, opRequest, ipGrant, opBusValid, ipBusReady, opBusWrite;
  logic              opTimeout, opAbort;

  mutex_requester #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD),
                    .GAP_LIMIT(GAP_LIMIT), .TIMEOUT(TIMEOUT)) dut (
    .ipClk(clk), .ipReset(ipReset), .ipCmdValid(ipCmdValid), .opCmdReady(opCmdReady),
    .ipCmdWrite(ipCmdWrite), .ipCmdLast(ipCmdLast), .ipCmdAddress(ipCmdAddress),
    .ipCmdData(ipCmdData), .opRspValid(opRspValid), .opRspData(opRspData),
    .opRequest(opRequest), .ipGrant(ipGrant), .opBusValid(opBusValid),
    .ipBusReady(ipBusReady), .opBusWrite(opBusWrite), .opBusAddress(opBusAddress),
    .opBusWriteData(opBusWriteData), .ipBusReadData(ipBusReadData),
    .opTimeout(opTimeout), .opAbort(opAbort));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic              w;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } bus_t;

  bus_t              exp_bus[$];
  logic [DATA_W-1:0] exp_rsp[$];
  int                bursts[$];
  int total = 0, bad = 0;
  int burst_cnt = 0, abort_cnt = 0, timeout_cnt = 0;
  bit grant_en = 1'b1;
  int drop_at = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s = 0x%0h", name, act);
    end
  endtask

  function automatic logic [DATA_W-1:0] rd_slave(input logic [ADDR_W-1:0] a);
    case (a)
      16'h0100: return 32'h0000_0011;
      16'h0104: return 32'h0000_0022;
      16'h0108: return 32'h0000_0033;
      default:  return {16'hBAD0, a};
    endcase
  endfunction

  task automatic drive_cmd(input logic w, input logic last, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d);
    bus_t e;
    ipCmdValid = 1'b1; ipCmdWrite = w; ipCmdLast = last; ipCmdAddress = a; ipCmdData = d;
    e.w = w; e.a = a; e.d = d;
    exp_bus.push_back(e);
  endtask

  task automatic wait_accept(input string name);
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (opCmdReady) begin
        @(posedge clk); #1;
        ipCmdValid = 1'b0;
        return;
      end
    end
    total++; bad++;
    $display("FAIL %s accept: no opCmdReady within 400 cycles, required acceptance", name);
    ipCmdValid = 1'b0;
  endtask

  task automatic send(input logic w, input logic last, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d, input string name);
    drive_cmd(w, last, a, d);
    wait_accept(name);
  endtask

  // Arbiter model: grants GRANT_DLY cycles after a request, optionally revokes mid-burst.
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    ipGrant = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!opRequest) begin
        ipGrant = 1'b0; wait_cnt = 0;
      end else if (ipGrant) begin
        if (drop_at >= 0 && burst_cnt == drop_at) begin
          ipGrant = 1'b0; drop_at = -1; wait_cnt = 0;
        end
      end else if (grant_en) begin
        wait_cnt++;
        if (wait_cnt >= GRANT_DLY) ipGrant = 1'b1;
      end
    end
  end

  initial begin
    ipBusReadData = '0;
    forever begin
      @(negedge clk); #1;
      ipBusReadData = rd_slave(opBusAddress);
    end
  end

  // Monitor / scoreboard
  initial begin
    bit rsp_due, req_prev;
    bus_t e;
    rsp_due = 1'b0; req_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rsp_due || opRspValid) chk("rsp_valid", opRspValid, rsp_due);
      if (opRspValid) begin
        if (exp_rsp.size() == 0) chk("rsp_extra", exp_rsp.size(), 1);
        else chk("rsp_data", opRspData, exp_rsp.pop_front());
      end
      rsp_due = 1'b0;
      if (opBusValid) begin
        chk("bus_valid_needs_grant", ipGrant, 1);
        if (ipBusReady) begin
          if (exp_bus.size() == 0) chk("bus_extra_xfer", exp_bus.size(), 1);
          else begin
            e = exp_bus.pop_front();
            chk("bus_write", opBusWrite, e.w);
            chk("bus_addr", opBusAddress, e.a);
            if (e.w) chk("bus_wdata", opBusWriteData, e.d);
          end
          rsp_due = !opBusWrite;
          burst_cnt++;
        end
      end
      if (opAbort) abort_cnt++;
      if (opTimeout) timeout_cnt++;
      if (req_prev && !opRequest) bursts.push_back(burst_cnt);
      if (!opRequest) burst_cnt = 0;
      req_prev = opRequest;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    ipReset = 1'b1; ipCmdValid = 1'b0; ipCmdWrite = 1'b0; ipCmdLast = 1'b0;
    ipCmdAddress = '0; ipCmdData = '0; ipBusReady = 1'b1;
    repeat (3) @(posedge clk);
    #1 ipReset = 1'b0;
    @(negedge clk);
    chk("reset opRequest", opRequest, 0);
    chk("reset opCmdReady", opCmdReady, 0);
    chk("reset opBusValid", opBusValid, 0);
    chk("reset opRspValid", opRspValid, 0);
    chk("reset opAbort", opAbort, 0);
    chk("reset opTimeout", opTimeout, 0);

    // Single write
    bursts.delete();
    @(posedge clk); #1;
    drive_cmd(1'b1, 1'b1, 16'h0010, 32'hDEAD_BEEF);
    @(negedge clk); chk("t1 request before", opRequest, 0);
    @(negedge clk); chk("t1 request rise", opRequest, 1);
    wait_accept("t1");
    @(negedge clk); chk("t1 bus valid", opBusValid, 1);
    @(negedge clk); chk("t1 request after xfer", opRequest, 0);
    repeat (4) @(negedge clk);
    chk("t1 grant cycles", bursts.size(), 1);
    if (bursts.size() > 0) chk("t1 burst len", bursts[0], 1);

    // Read burst of 3
    bursts.delete();
    @(posedge clk); #1;
    exp_rsp.push_back(32'h11); exp_rsp.push_back(32'h22); exp_rsp.push_back(32'h33);
    send(1'b0, 1'b0, 16'h0100, '0, "t2a");
    send(1'b0, 1'b0, 16'h0104, '0, "t2b");
    send(1'b0, 1'b1, 16'h0108, '0, "t2c");
    repeat (8) @(negedge clk);
    chk("t2 responses left", exp_rsp.size(), 0);
    chk("t2 grant cycles", bursts.size(), 1);
    if (bursts.size() > 0) chk("t2 burst len", bursts[0], 3);

    // 20 writes split by MAX_HOLD
    bursts.delete();
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++)
      send(1'b1, i == 19, 16'h1000 + 16'(i * 4), 32'hA500_0000 + i, "t3");
    repeat (10) @(negedge clk);
    chk("t3 grant cycles", bursts.size(), 2);
    if (bursts.size() == 2) begin
      chk("t3 burst1 len", bursts[0], 16);
      chk("t3 burst2 len", bursts[1], 4);
    end

    // Grant revoked after 2 of 5
    bursts.delete();
    a0 = abort_cnt;
    drop_at = 2;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++)
      send(1'b1, i == 4, 16'h2000 + 16'(i), 32'h5A5A_0000 + i, "t4");
    repeat (10) @(negedge clk);
    chk("t4 abort pulses", abort_cnt - a0, 1);
    chk("t4 grant cycles", bursts.size(), 2);
    if (bursts.size() == 2) begin
      chk("t4 burst1 len", bursts[0], 2);
      chk("t4 burst2 len", bursts[1], 3);
    end
    chk("t4 bus left", exp_bus.size(), 0);

    // Auto-release after GAP_LIMIT idle cycles
    @(posedge clk); #1;
    send(1'b1, 1'b0, 16'h0300, 32'h1234_5678, "t5");
    @(negedge clk); chk("t5 bus valid", opBusValid, 1);
    repeat (3) @(negedge clk);
    @(negedge clk); chk("t5 request held", opRequest, 1);
    @(negedge clk); chk("t5 request released", opRequest, 0);
    repeat (4) @(negedge clk);

    // Grant never given
    grant_en = 1'b0;
    @(posedge clk); #1;
    drive_cmd(1'b1, 1'b1, 16'h0400, 32'hCAFE_F00D);
`ifdef MUTEX_REQUESTER_TIMEOUT_EN
    begin : t6_timeout
      int hi, n;
      bit seen;
      hi = 0; n = 0; seen = 1'b0;
      while (!seen && n < 60) begin
        @(negedge clk); n++;
        if (opTimeout) seen = 1'b1;
        else if (opRequest) hi++;
      end
      chk("t6 timeout pulse", seen, 1);
      chk("t6 request cycles", hi, TIMEOUT);
      chk("t6 request dropped", opRequest, 0);
    end
`else
    begin : t6_hold
      int errs;
      errs = 0;
      repeat (2) @(negedge clk);
      repeat (100) begin
        @(negedge clk);
        if (!opRequest || opTimeout) errs++;
      end
      chk("t6 request held 100", errs, 0);
    end
`endif
    grant_en = 1'b1;
    wait_accept("t6");
    repeat (6) @(negedge clk);
    chk("t6 bus left", exp_bus.size(), 0);

    // Reset mid-burst with a stalled read in the holding register
    ipBusReady = 1'b0;
    @(posedge clk); #1;
    send(1'b0, 1'b1, 16'h0500, '0, "t7");
    @(negedge clk); chk("t7 read stalled", opBusValid, 1);
    @(posedge clk); #1 ipReset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 ipReset = 1'b0;
    exp_bus.delete();
    @(negedge clk);
    chk("t7 opRequest", opRequest, 0);
    chk("t7 opBusValid", opBusValid, 0);
    chk("t7 opCmdReady", opCmdReady, 0);
    chk("t7 opRspValid", opRspValid, 0);
    ipBusReady = 1'b1;
    repeat (10) @(negedge clk);
    chk("t7 stays idle", opRequest, 0);

    chk("final responses left", exp_rsp.size(), 0);
`ifndef MUTEX_REQUESTER_TIMEOUT_EN
    chk("final timeout pulses", timeout_cnt, 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mutex_requester.md
# mutex_requester

Client-side front end for the round-robin mutual-exclusion arbiter that guards shared peripherals. It accepts read/write commands from one local master and raises a request line toward the arbiter. Once granted, it issues the commands onto the shared bus and drops the request to release the lock. One instance sits between each master and its bit of the arbiter's request/grant vectors.

## Interface
Parameters:
- ADDR_W, 16, bus address width
- DATA_W, 32, bus data width
- MAX_HOLD, 16, maximum bus transfers per grant (≥1)
- GAP_LIMIT, 4, idle cycles in ACTIVE with no command before auto-release (≥1)
- TIMEOUT, 1024, grant-wait limit in cycles (used only with the timeout macro)

Ports:
- ipClk  in  1  clock
- ipReset  in  1  synchronous, active-high reset
- ipCmdValid  in  1  local command valid
- opCmdReady  out  1  command accepted when ipCmdValid & opCmdReady
- ipCmdWrite  in  1  1 = write, 0 = read
- ipCmdLast  in  1  last command of the burst; release after it
- ipCmdAddress  in  ADDR_W  command address
- ipCmdData  in  DATA_W  write data
- opRspValid  out  1  one-cycle pulse, read data valid
- opRspData  out  DATA_W  read data
- opRequest  out  1  to arbiter request bit
- ipGrant  in  1  from arbiter grant bit
- opBusValid  out  1  bus transfer valid
- ipBusReady  in  1  bus transfer accepted
- opBusWrite, opBusAddress, opBusWriteData  out  1/ADDR_W/DATA_W  bus command
- ipBusReadData  in  DATA_W  read data, valid in the transfer cycle
- opTimeout  out  1  one-cycle pulse, grant wait abandoned
- opAbort  out  1  one-cycle pulse, grant lost while ACTIVE

## Operation
- ipReset is registered once internally. All state clears on the second edge with ipReset high.
- Reset values:
  - all outputs 0
  - state IDLE
  - holding register empty
  - counters 0
- The one-entry holding register carries Write/Last/Address/Data.
- opCmdReady = (state==ACTIVE) & (holding empty | bus transfer this cycle).
- opBusValid = holding full & (state==ACTIVE) & ipGrant. The bus fields come straight from the holding register.
- IDLE: opRequest=0. If ipCmdValid, go to REQUEST.
- REQUEST: opRequest=1.
  - ipGrant=1 → ACTIVE; clear the transfer and gap counters.
- ACTIVE: opRequest=1. Each completed transfer (opBusValid & ipBusReady) increments the transfer count.
  - Completed transfer with Last=1 → RELEASE.
  - Completed transfer with count reaching MAX_HOLD → RELEASE. Remaining commands go through a new request cycle.
  - Holding register empty and ipCmdValid=0 for GAP_LIMIT consecutive cycles → RELEASE.
  - ipGrant=0 → RELEASE, with opAbort pulsed. The holding register is kept, and its contents are issued after the next grant.
- RELEASE: opRequest=0 and opCmdReady=0.
  - Wait until ipGrant=0, then go to IDLE.
  - This guarantees a stale grant is never reused.
- Read response: on a completed read transfer, ipBusReadData is registered to opRspData, and opRspValid pulses on the next cycle.
- The transfer counter is wide enough to hold MAX_HOLD. The gap counter saturates at GAP_LIMIT.
- Reset mid-burst:
  - the holding register is discarded
  - opRequest drops with the other outputs
  - no response is produced for an in-flight read

## Timing
- Request: opRequest rises 1 cycle after ipCmdValid is seen in IDLE.
- Bus issue: the first opBusValid comes earliest 2 cycles after ipGrant rises (1 cycle to ACTIVE, 1 cycle to accept into holding).
- Throughput: 1 transfer per cycle with ipBusReady held high.
- Release: opRequest falls 1 cycle after the releasing transfer.
- Back-to-back grants: minimum 1 cycle with opRequest=0 between grants. The next IDLE→REQUEST follows immediately once ipGrant=0.
- Simultaneous events in ACTIVE:
  - A Last transfer coinciding with the MAX_HOLD count causes one release.
  - Grant loss in the same cycle as ipBusReady means the transfer does not count, because opBusValid is gated low.

## Configuration
- MUTEX_REQUESTER_TIMEOUT_EN defined:
  - A counter runs in REQUEST.
  - When it reaches TIMEOUT cycles without a grant: opTimeout pulses, opRequest drops, go to RELEASE.
  - The pending command remains offered by the master.
- MUTEX_REQUESTER_TIMEOUT_EN undefined:
  - REQUEST waits indefinitely.
  - opTimeout is tied to 0 and the TIMEOUT parameter is ignored.

## Test plan
- Single write (addr 0x0010, data 0xDEADBEEF, Last=1), grant 2 cycles after request → one bus write with those values; opRequest low 1 cycle after the transfer; returns to IDLE after grant drops.
- Read burst of 3 (Last on 3rd), ipBusReadData = 0x11, 0x22, 0x33 → opRspValid pulses with 0x11, 0x22, 0x33, each 1 cycle after its transfer; a single request/grant cycle.
- 20 consecutive writes with MAX_HOLD=16, Last only on the 20th → 16 transfers, release, re-request, 4 transfers; the request is low for ≥1 cycle between.
- Grant forced low after 2 of 5 transfers → opAbort pulse; opBusValid low in the same cycle; the remaining 3 transfers complete after re-grant with no duplicates and no loss.
- With MUTEX_REQUESTER_TIMEOUT_EN, TIMEOUT=8, grant never given → opTimeout pulse after 8 REQUEST cycles, opRequest low, re-request follows. Without the macro → the request stays high for 100 cycles and opTimeout stays 0.
- ipReset asserted mid-burst for 2 cycles → all outputs 0 after the second edge; no opRspValid for the in-flight read.
